// File: rtl/ks_subtractor_pipe_if.sv
// Operand/result bundle for the Kogge-Stone subtractor pipeline.
// No storage; the master drives operands and out_ready, the slave returns results.
// Backpressure rides on in_ready/out_ready inside this bundle.
interface ks_subtractor_pipe_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         borrow;
  logic         ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, borrow, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, borrow, ovf
  );
endinterface

// File: rtl/ks_subtractor_pipe.sv
// Pipelined a - b - bin on a Kogge-Stone prefix carry network, with borrow and signed overflow.
// Latency LAT = clog2(N) + 2 cycles from accept to out_valid; one result per cycle sustained.
// Bubble-collapsing valid/ready stages; in_ready is combinational from out_ready through the valid chain.
module ks_subtractor_pipe #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  ks_subtractor_pipe_if.slave bus
);
  localparam int LVL = $clog2(N);
  localparam int LAT = LVL + 2;

  // Stage s valid bit; stage 0 holds g/p, stages 1..LVL hold prefix levels, stage LAT-1 holds results.
  logic [LAT-1:0] r_vld;
  // Stage s may load this cycle: it is empty, or every stage downstream of it moves.
  logic [LAT-1:0] w_ld;

  // Per-stage datapath registers, indexed by stage 0..LVL.
  logic [N-1:0] r_g  [LVL+1];  // group generate (bit 0 already includes carry-in)
  logic [N-1:0] r_pg [LVL+1];  // group propagate
  logic [N-1:0] r_p  [LVL+1];  // original per-bit propagate, needed for the final XOR
  logic [LVL:0] r_c0;          // carry-in = ~bin
  logic [LVL:0] r_sa;          // sign of a
  logic [LVL:0] r_sb;          // sign of b

  // Prefix level outputs, index k = level feeding stage k.
  logic [N-1:0] w_go [LVL+1];
  logic [N-1:0] w_po [LVL+1];

  // Result stage.
  logic [N-1:0] r_diff;
  logic         r_borrow;
  logic         r_ovf;
  logic [N:0]   w_cy;
  logic [N-1:0] w_diff;

  // Load enables: a stage frees up when it or any stage below it is empty, or the consumer takes.
  always_comb begin : p_ld
    logic v_free;
    w_ld = '0;
    for (int s = 0; s < LAT; s++) begin
      v_free = bus.out_ready;
      for (int j = s; j < LAT; j++) begin
        v_free = v_free | ~r_vld[j];
      end
      w_ld[s] = v_free;
    end
  end

  assign bus.in_ready  = w_ld[0];
  assign bus.out_valid = r_vld[LAT-1];
  assign bus.diff      = r_diff;
  assign bus.borrow    = r_borrow;
  assign bus.ovf       = r_ovf;

  // Valid chain: each loading stage takes the valid of the stage above (bubbles collapse).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      if (w_ld[0]) r_vld[0] <= bus.in_valid;
      for (int s = 1; s < LAT; s++) begin
        if (w_ld[s]) r_vld[s] <= r_vld[s-1];
      end
    end
  end

  // One Kogge-Stone level per stage; span doubles each level, low positions pass through.
  always_comb begin
    for (int k = 0; k <= LVL; k++) begin
      w_go[k] = '0;
      w_po[k] = '0;
    end
    for (int k = 1; k <= LVL; k++) begin
      w_go[k] = r_g[k-1];
      w_po[k] = r_pg[k-1];
      for (int i = 0; i < N; i++) begin
        if (i >= (1 << (k - 1))) begin
          w_go[k][i] = r_g[k-1][i] | (r_pg[k-1][i] & r_g[k-1][i - (1 << (k - 1))]);
          w_po[k][i] = r_pg[k-1][i] & r_pg[k-1][i - (1 << (k - 1))];
        end
      end
    end
  end

  // Operand capture (stage 0) and prefix stages; data only moves with a valid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= LVL; k++) begin
        r_g[k]  <= '0;
        r_pg[k] <= '0;
        r_p[k]  <= '0;
      end
      r_c0 <= '0;
      r_sa <= '0;
      r_sb <= '0;
    end else begin
      if (bus.in_valid && w_ld[0]) begin
        // Carry-in folded into bit 0 as generate position -1 (its propagate is 0).
        r_g[0]     <= (bus.a & ~bus.b) |
                      {{(N-1){1'b0}}, (bus.a[0] ^ ~bus.b[0]) & ~bus.bin};
        r_pg[0]    <= (bus.a ^ ~bus.b) & ~{{(N-1){1'b0}}, 1'b1};
        r_p[0]     <= bus.a ^ ~bus.b;
        r_c0[0]    <= ~bus.bin;
        r_sa[0]    <= bus.a[N-1];
        r_sb[0]    <= bus.b[N-1];
      end
      for (int k = 1; k <= LVL; k++) begin
        if (w_ld[k] && r_vld[k-1]) begin
          r_g[k]  <= w_go[k];
          r_pg[k] <= w_po[k];
          r_p[k]  <= r_p[k-1];
          r_c0[k] <= r_c0[k-1];
          r_sa[k] <= r_sa[k-1];
          r_sb[k] <= r_sb[k-1];
        end
      end
    end
  end

  // Carry into bit i is the prefix generate of bit i-1; carry into bit 0 is the carry-in.
  always_comb begin
    w_cy   = {r_g[LVL], r_c0[LVL]};
    w_diff = r_p[LVL] ^ w_cy[N-1:0];
  end

  // Result stage: held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_ld[LAT-1] && r_vld[LAT-2]) begin
      r_diff   <= w_diff;
      r_borrow <= ~w_cy[N];
      r_ovf    <= (r_sa[LVL] ^ r_sb[LVL]) & (w_diff[N-1] ^ r_sa[LVL]);
    end
  end
endmodule

// File: tb/tb_ks_subtractor_pipe.sv
// Self-checking bench for ks_subtractor_pipe (N = 8, LAT = 5).
// Scoreboard model uses plain integer arithmetic on a - b - bin.
// Covers reset, latency, directed vectors, backpressure, random traffic, mid-stream reset.
module tb_ks_subtractor_pipe;
  localparam int N   = 8;
  localparam int LAT = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ks_subtractor_pipe_if #(.N(N)) bus ();

  ks_subtractor_pipe #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       br;
    logic       ov;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  res_t obs_q[$];
  bit   acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int   ua;
    int   ub;
    int   sa;
    int   sb;
    int   r;
    res_t x;
    ua   = int'(a);
    ub   = int'(b);
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    r    = ua - ub - int'(bin);
    x.d  = 8'(r);
    x.br = (ua < ub + int'(bin));
    r    = sa - sb - int'(bin);
    x.ov = (r < -128) || (r > 127);
    return x;
  endfunction

  // One clock: sample handshakes on the falling edge, then step past the rising edge.
  task automatic cycle();
    res_t o;
    res_t e;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    if (acc) exp_q.push_back(model(bus.a, bus.b, bus.bin));
    if (bus.out_valid && bus.out_ready) begin
      o = {bus.diff, bus.borrow, bus.ovf};
      obs_q.push_back(o);
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("diff",   o.d,  e.d);
        chk("borrow", o.br, e.br);
        chk("ovf",    o.ov, e.ov);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 60) begin
      cycle();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  logic [7:0] ta  [5] = '{8'hAA, 8'h66, 8'hCC, 8'h00, 8'hFF};
  logic [7:0] tbv [5] = '{8'h66, 8'hAA, 8'h3C, 8'h00, 8'hFF};
  logic       tbi [5] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
  logic [7:0] td  [5] = '{8'h44, 8'hBC, 8'h8F, 8'hFF, 8'h00};
  logic       tbr [5] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0};
  logic       tov [5] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b0};

  logic [7:0] ba [8];
  logic [7:0] bb [8];
  logic       bbi[8];

  initial begin
    int         n;
    int         idx;
    int         sent;
    int         cyc;
    logic [9:0] held;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_diff",      bus.diff,      0);
    chk("rst_borrow",    bus.borrow,    0);
    chk("rst_ovf",       bus.ovf,       0);
    chk("rst_in_ready",  bus.in_ready,  1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Directed: first vector alone to measure latency
    obs_q.delete();
    bus.in_valid = 1'b1;
    bus.a = ta[0]; bus.b = tbv[0]; bus.bin = tbi[0];
    cycle();
    chk("dir0_accept", acc, 1);
    bus.in_valid = 1'b0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (obs_q.size() == 0 && n < 20);
    chk("latency", n, LAT);

    // Remaining directed vectors back to back
    for (int i = 1; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.a = ta[i]; bus.b = tbv[i]; bus.bin = tbi[i];
      cycle();
      chk($sformatf("dir%0d_accept", i), acc, 1);
    end
    drain();
    chk("dir_count", obs_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < obs_q.size()) begin
        chk($sformatf("dir%0d_diff", i),   obs_q[i].d,  td[i]);
        chk($sformatf("dir%0d_borrow", i), obs_q[i].br, tbr[i]);
        chk($sformatf("dir%0d_ovf", i),    obs_q[i].ov, tov[i]);
      end
    end

    // Backpressure: consumer stalled, 8 operands offered back to back
    for (int i = 0; i < 8; i++) begin
      ba[i]  = 8'($urandom);
      bb[i]  = 8'($urandom);
      bbi[i] = 1'($urandom);
    end
    obs_q.delete();
    bus.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.a = ba[idx]; bus.b = bb[idx]; bus.bin = bbi[idx];
      cycle();
      if (acc && idx < 7) idx++;
    end
    chk("bp_accepted",  idx,           LAT);
    chk("bp_in_ready",  bus.in_ready,  0);
    chk("bp_out_valid", bus.out_valid, 1);
    held = {bus.diff, bus.borrow, bus.ovf};
    repeat (3) cycle();
    chk("bp_hold",        {bus.diff, bus.borrow, bus.ovf}, held);
    chk("bp_still_five",  idx, LAT);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_same_cycle", bus.in_ready, 1);
    n = 0;
    while (idx < 8 && n < 20) begin
      bus.in_valid = 1'b1;
      bus.a = ba[idx]; bus.b = bb[idx]; bus.bin = bbi[idx];
      cycle();
      if (acc) idx++;
      n++;
    end
    drain();
    chk("bp_results", obs_q.size(), 8);

    // Random traffic with random stalls on both sides
    sent = 0;
    cyc  = 0;
    while (sent < 10000 && cyc < 40000) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.a         = 8'($urandom);
      bus.b         = 8'($urandom);
      bus.bin       = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (acc) sent++;
      cyc++;
    end
    chk("rand_sent", sent, 10000);
    drain();
    chk("rand_left", exp_q.size(), 0);

    // Reset with three results in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 8'($urandom); bus.b = 8'($urandom); bus.bin = 1'($urandom);
      cycle();
    end
    bus.in_valid = 1'b0;
    repeat (4) cycle();
    chk("pre_rst_out_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_diff",      bus.diff,      0);
    chk("mid_rst_borrow",    bus.borrow,    0);
    chk("mid_rst_ovf",       bus.ovf,       0);
    exp_q.delete();
    obs_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("after_rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a = 8'h12; bus.b = 8'h34; bus.bin = 1'b0;
    cycle();
    drain();
    chk("after_rst_count", obs_q.size(), 1);
    if (obs_q.size() >= 1) begin
      chk("after_rst_diff",   obs_q[0].d,  8'hDE);
      chk("after_rst_borrow", obs_q[0].br, 1);
      chk("after_rst_ovf",    obs_q[0].ov, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ks_subtractor_pipe.md
# ks_subtractor_pipe

Pipelined, handshaked N-bit subtractor built on the same Kogge-Stone parallel-prefix carry network as the team's adder, computing diff = A − B − bin. It is the inverse-direction companion to the Kogge-Stone adder and sits on a valid/ready datapath. It accepts one operand pair per cycle, applies backpressure through a bubble-collapsing register pipeline, and returns results in order with borrow and signed-overflow flags.

## Interface
- N, default 8: operand width; any N ≥ 2. LVL = ceil(log2 N) prefix levels; LAT = LVL + 2 pipeline stages (5 for N = 8).
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept this cycle.
- a  input  N  minuend, unsigned or two's complement.
- b  input  N  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result presented.
- out_ready  input  1  consumer accepts this cycle.
- diff  output  N  (a − b − bin) mod 2^N.
- borrow  output  1  1 when unsigned a < b + bin.
- ovf  output  1  signed overflow: a[N−1] ≠ b[N−1] and diff[N−1] ≠ a[N−1].

## Operation
- Subtraction is performed as a + ~b + ~bin; cout is the carry out of bit N−1; borrow = ~cout.
- Stage 1: register g = a & ~b, p = a ^ ~b, carry-in c0 = ~bin, and the sign bits a[N−1], b[N−1].
- Stages 2..LVL+1: one Kogge-Stone prefix level per stage, span 2^(k−1) at level k. Group generate G = g_hi | (p_hi & g_lo); group propagate P = p_hi & p_lo. Positions with no lower partner pass through unchanged. Carry-in is folded in as generate position −1.
- Final stage: diff[i] = p[i] ^ carry[i]; borrow = ~carry[N]; ovf from the registered sign bits and diff[N−1].
- Each stage holds one valid bit plus its data.
- A stage loads when it is empty or when its contents are leaving downstream that cycle, so bubbles collapse.
- in_ready = stage-1 empty or stage 1 advancing. in_ready is combinational from out_ready through the stage-valid chain.
- The last stage holds diff, borrow and ovf stable while out_valid = 1 and out_ready = 0.
- Results emerge strictly in acceptance order, with no loss or duplication.
- Capacity: LAT results in flight.
- Reset (asynchronous assert, any time including mid-stream): all stage valids clear and all data registers go to 0. Out of reset, out_valid = 0, diff = 0, borrow = 0, ovf = 0, and in_ready = 1 in the first cycle after deassertion. In-flight operations are discarded.
- Input values are ignored when in_valid = 0. Inputs are sampled only on an accept (in_valid & in_ready).

## Timing
- Transfer accepted at edge k with no stalls: out_valid = 1 after edge k + LAT − 1, i.e. the LAT-th edge counting k. For N = 8, result visible in the cycle after edge k+4.
- Throughput: one result per cycle when out_ready is held high.
- Output transfer occurs on an edge with out_valid & out_ready.
- Simultaneous accept and emit when full: allowed. The pipeline shifts and in_ready stays 1.
- With out_ready = 0 and continuous in_valid: exactly LAT operands are accepted, then in_ready = 0 until out_ready rises. in_ready returns to 1 in the same cycle out_ready = 1.
- rst_n deassertion is synchronised externally; the block only requires it glitch-free.

## Test plan
- N=8, a=0xAA, b=0x66, bin=0 -> diff=0x44, borrow=0, ovf=1, out_valid 5 cycles after accept.
- a=0x66, b=0xAA, bin=0 -> diff=0xBC, borrow=1, ovf=1. Then a=0xCC, b=0x3C, bin=1 -> diff=0x8F, borrow=0, ovf=0, on the next consecutive cycle.
- a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow=1, ovf=0. a=0xFF, b=0xFF, bin=0 -> diff=0x00, borrow=0, ovf=0.
- Backpressure: out_ready=0, 8 back-to-back operands -> exactly 5 accepted, in_ready=0 thereafter, output held stable. Release out_ready -> all 8 results in order, none lost or duplicated.
- Random out_ready/in_valid toggling over 10k random vectors -> every result matches the reference model (a − b − bin), including borrow and ovf, in order.
- Assert rst_n low with 3 results in flight -> out_valid drops immediately and outputs read 0. After release, in_ready = 1 and the next operand's result is the first one emitted.
